// File: rtl/givens_rot_cordic.sv
// Iterative rotation-mode CORDIC Givens row update with gain compensation.
// Optional quadrant pre-rotation for a full +/-pi angle range: define GIVENS_QUAD_PREROT_EN.
module givens_rot_cordic #(
  parameter int STG  = 12,
  parameter int SIZE = 16,
  parameter int INT  = 4,
  parameter int FRAC = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   theta_start,
  input  logic signed [SIZE-1:0] theta,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [SIZE-1:0] in_x,
  input  logic signed [SIZE-1:0] in_y,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [SIZE-1:0] out_x,
  output logic signed [SIZE-1:0] out_y,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  // state     | meaning
  // IDLE      | waiting for theta_start; angle not yet latched
  // WAIT_PAIR | angle held, accepting the next (x, y) pair
  // ROT       | one micro-rotation per cycle, STG cycles
  // SCALE     | gain compensation and saturation into the output regs
  // OUT       | result presented until the consumer takes it
  typedef enum logic [2:0] {IDLE, WAIT_PAIR, ROT, SCALE, OUT} state_t;

  localparam int W  = SIZE + 1;
  localparam int PW = 2 * SIZE + 2;
  localparam int OW = INT + FRAC;
  localparam logic signed [W-1:0]  GAIN      = W'(2488);
  localparam logic [3:0]           LAST_ITER = 4'(STG - 1);
  localparam logic signed [PW-1:0] SAT_MAX   = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN   = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`ifdef GIVENS_QUAD_PREROT_EN
  localparam logic signed [W-1:0]  HALF_PI   = W'(16'h1922);
`endif

  function automatic logic signed [W-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = W'(16'h0C90);
      4'd1:    atan_lut = W'(16'h076B);
      4'd2:    atan_lut = W'(16'h03EB);
      4'd3:    atan_lut = W'(16'h01FD);
      4'd4:    atan_lut = W'(16'h00FF);
      4'd5:    atan_lut = W'(16'h007F);
      4'd6:    atan_lut = W'(16'h003F);
      4'd7:    atan_lut = W'(16'h001F);
      4'd8:    atan_lut = W'(16'h000F);
      4'd9:    atan_lut = W'(16'h0007);
      4'd10:   atan_lut = W'(16'h0003);
      4'd11:   atan_lut = W'(16'h0001);
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic logic [SIZE-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[SIZE-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[SIZE-1:0];
    else                  sat = v[SIZE-1:0];
  endfunction

  state_t                 state;
  logic signed [SIZE-1:0] theta_r;
  logic signed [W-1:0]    x_r, y_r, z_r;
  logic [3:0]             iter;
  logic                   last_r;

  logic signed [W-1:0]    theta_w, in_x_w, in_y_w, x_sh, y_sh, atan_i;
  logic signed [PW-1:0]   prod_x, prod_y;

  assign theta_w = W'(theta_r);
  assign in_x_w  = W'(in_x);
  assign in_y_w  = W'(in_y);
  assign x_sh    = x_r >>> iter;
  assign y_sh    = y_r >>> iter;
  assign atan_i  = atan_lut(iter);
  assign prod_x  = PW'(x_r) * PW'(GAIN);
  assign prod_y  = PW'(y_r) * PW'(GAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      theta_r   <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      iter      <= '0;
      last_r    <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (theta_start) begin
            theta_r  <= theta;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= WAIT_PAIR;
          end
        end
        WAIT_PAIR: begin
          if (in_valid) begin
`ifdef GIVENS_QUAD_PREROT_EN
            // Fold angles beyond +/-pi/2 back into the convergence range.
            if (theta_w > HALF_PI) begin
              x_r <= -in_y_w;
              y_r <= in_x_w;
              z_r <= theta_w - HALF_PI;
            end else if (theta_w < -HALF_PI) begin
              x_r <= in_y_w;
              y_r <= -in_x_w;
              z_r <= theta_w + HALF_PI;
            end else begin
              x_r <= in_x_w;
              y_r <= in_y_w;
              z_r <= theta_w;
            end
`else
            x_r <= in_x_w;
            y_r <= in_y_w;
            z_r <= theta_w;
`endif
            last_r   <= in_last;
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= ROT;
          end
        end
        ROT: begin
          if (!z_r[W-1]) begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_i;
          end else begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_i;
          end
          iter <= iter + 4'd1;
          if (iter == LAST_ITER) state <= SCALE;
        end
        SCALE: begin
          out_x     <= sat(prod_x >>> FRAC);
          out_y     <= sat(prod_y >>> FRAC);
          out_last  <= last_r;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_r) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              in_ready <= 1'b1;
              state    <= WAIT_PAIR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
